kbd_color_sequencer: RTL and testbench

Keyboard-driven color command sequencer between the PS/2 keyboard controller and the VGA display controller. Consumes received scan-code bytes, decodes make/break/extended sequences into color commands, and stages the result in a pending register. Pending changes are committed to the display's color input only on a frame-start strobe, so the visible color never changes mid-frame.

---
 rtl/kbd_color_sequencer.sv | 153 +++++++++++++++
 tb/tb_kbd_color_sequencer.sv | 288 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/kbd_color_sequencer.sv
`default_nettype none
//------------------------------------------------------------------------------
// Module      : kbd_color_sequencer
// Description : Decodes PS/2 scan-code bytes into color commands, stages them in
//               a pending register, and commits the pending color to the display
//               only on a frame-start strobe so the color never changes mid-frame.
// Revision    : 1.0 - initial release
//------------------------------------------------------------------------------
module kbd_color_sequencer #(
  parameter logic [2:0] DEFAULT_COLOR  = 3'b000,
  parameter int         TIMEOUT_CYCLES = 50000
) (
  input  logic       boardClk,
  input  logic       reset,
  input  logic       codeValid,
  input  logic [7:0] codeData,
  input  logic       frameStart,
  output logic [2:0] colorOut,
  output logic       cmdPending,
  output logic       commitStrobe,
  output logic       errPulse
);

  localparam int                   c_TIMER_W    = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [c_TIMER_W-1:0] c_TIMER_LAST = c_TIMER_W'(TIMEOUT_CYCLES - 1);
  localparam logic [c_TIMER_W-1:0] c_TIMER_ONE  = c_TIMER_W'(1);

  localparam logic [7:0] c_CODE_BREAK = 8'hF0;
  localparam logic [7:0] c_CODE_EXT   = 8'hE0;
  localparam logic [7:0] c_CODE_ACK   = 8'hFA;
  localparam logic [7:0] c_CODE_BAT   = 8'hAA;
  localparam logic [7:0] c_KEY_R      = 8'h2D;
  localparam logic [7:0] c_KEY_G      = 8'h34;
  localparam logic [7:0] c_KEY_B      = 8'h32;
  localparam logic [7:0] c_KEY_W      = 8'h1D;
  localparam logic [7:0] c_KEY_K      = 8'h42;
  localparam logic [7:0] c_KEY_SPACE  = 8'h29;
  localparam logic [7:0] c_KEY_UP     = 8'h75;
  localparam logic [7:0] c_KEY_DOWN   = 8'h72;

  typedef enum logic [1:0] {
    ST_IDLE      = 2'd0,
    ST_BREAK     = 2'd1,
    ST_EXT       = 2'd2,
    ST_EXT_BREAK = 2'd3
  } state_t;

  state_t               r_state;
  state_t               w_nextState;
  logic [c_TIMER_W-1:0] r_timer;
  logic [2:0]           r_pendingColor;
  logic                 w_apply;
  logic [2:0]           w_newColor;
  logic                 w_err;
  logic                 w_timeout;
  logic                 w_commit;

  // A prefix state that sees no byte for the full window gives up.
  assign w_timeout = (r_state != ST_IDLE) && !codeValid && (r_timer == c_TIMER_LAST);
  // Commit uses the pending color as it stood before any same-cycle command.
  assign w_commit  = frameStart && cmdPending;

  // Decoder state register.
  always_ff @(posedge boardClk or negedge reset) begin
    if (!reset) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_nextState;
    end
  end

  // Next-state decode and command generation from the incoming byte.
  always_comb begin
    w_nextState = r_state;
    w_apply     = 1'b0;
    w_newColor  = r_pendingColor;
    w_err       = 1'b0;
    if (codeValid) begin
      case (r_state)
        ST_IDLE: begin
          case (codeData)
            c_CODE_BREAK: w_nextState = ST_BREAK;
            c_CODE_EXT:   w_nextState = ST_EXT;
            c_CODE_ACK, c_CODE_BAT: begin
              w_nextState = ST_IDLE;
            end
            c_KEY_R:     begin w_apply = 1'b1; w_newColor = r_pendingColor ^ 3'b100; end
            c_KEY_G:     begin w_apply = 1'b1; w_newColor = r_pendingColor ^ 3'b010; end
            c_KEY_B:     begin w_apply = 1'b1; w_newColor = r_pendingColor ^ 3'b001; end
            c_KEY_W:     begin w_apply = 1'b1; w_newColor = 3'b111; end
            c_KEY_K:     begin w_apply = 1'b1; w_newColor = 3'b000; end
            c_KEY_SPACE: begin w_apply = 1'b1; w_newColor = DEFAULT_COLOR; end
            default:     w_err = 1'b1;
          endcase
        end
        ST_EXT: begin
          w_nextState = ST_IDLE;
          case (codeData)
            c_CODE_BREAK: w_nextState = ST_EXT_BREAK;
            c_CODE_EXT:   w_nextState = ST_EXT;
            c_KEY_UP:     begin w_apply = 1'b1; w_newColor = r_pendingColor + 3'd1; end
            c_KEY_DOWN:   begin w_apply = 1'b1; w_newColor = r_pendingColor - 3'd1; end
            default:      w_err = 1'b1;
          endcase
        end
        // Released key: the byte is swallowed without effect.
        default: w_nextState = ST_IDLE;
      endcase
    end else if (w_timeout) begin
      w_nextState = ST_IDLE;
      w_err       = 1'b1;
    end
  end

  // Prefix timer: runs only while waiting in a prefix state, cleared by any byte.
  always_ff @(posedge boardClk or negedge reset) begin
    if (!reset) begin
      r_timer <= '0;
    end else if (codeValid || (r_state == ST_IDLE) || (w_nextState == ST_IDLE)) begin
      r_timer <= '0;
    end else begin
      r_timer <= r_timer + c_TIMER_ONE;
    end
  end

  // Pending color staging and frame-synchronous commit to the display.
  always_ff @(posedge boardClk or negedge reset) begin
    if (!reset) begin
      r_pendingColor <= DEFAULT_COLOR;
      colorOut       <= DEFAULT_COLOR;
      cmdPending     <= 1'b0;
      commitStrobe   <= 1'b0;
      errPulse       <= 1'b0;
    end else begin
      if (w_apply) begin
        r_pendingColor <= w_newColor;
      end
      if (w_commit) begin
        colorOut <= r_pendingColor;
      end
      // A command landing with a commit keeps the flag so its value commits next frame.
      if (w_apply) begin
        cmdPending <= 1'b1;
      end else if (w_commit) begin
        cmdPending <= 1'b0;
      end
      commitStrobe <= w_commit;
      errPulse     <= w_err;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_kbd_color_sequencer.sv
`default_nettype none
//------------------------------------------------------------------------------
// Module      : tb_kbd_color_sequencer
// Description : Self-checking bench: directed vector table, hand-written
//               multi-cycle sequences and randomized traffic against a model.
// Revision    : 1.0 - initial release
//------------------------------------------------------------------------------
module tb_kbd_color_sequencer;

  localparam logic [2:0] DEF = 3'b010;
  localparam int         TMO = 16;

  logic       boardClk   = 1'b0;
  logic       reset      = 1'b0;
  logic       codeValid  = 1'b0;
  logic [7:0] codeData   = 8'h00;
  logic       frameStart = 1'b0;
  logic [2:0] colorOut;
  logic       cmdPending;
  logic       commitStrobe;
  logic       errPulse;

  int checks   = 0;
  int failures = 0;

  kbd_color_sequencer #(
    .DEFAULT_COLOR  (DEF),
    .TIMEOUT_CYCLES (TMO)
  ) dut (
    .boardClk     (boardClk),
    .reset        (reset),
    .codeValid    (codeValid),
    .codeData     (codeData),
    .frameStart   (frameStart),
    .colorOut     (colorOut),
    .cmdPending   (cmdPending),
    .commitStrobe (commitStrobe),
    .errPulse     (errPulse)
  );

  always #5 boardClk = ~boardClk;

  // ---------------- behavioural model ----------------
  // mMode: 0 normal, 1 after F0, 2 after E0, 3 after E0 F0
  int         mMode;
  int         mIdle;
  logic [2:0] mPend;
  logic [2:0] mColor;
  bit         mFlag;
  bit         mStrobe;
  bit         mErr;

  task automatic modelReset();
    mMode = 0; mIdle = 0; mPend = DEF; mColor = DEF;
    mFlag = 0; mStrobe = 0; mErr = 0;
  endtask

  function automatic bit makeCmd(input logic [7:0] d, input logic [2:0] cur,
                                 output logic [2:0] nv);
    nv = cur;
    case (d)
      8'h2D: nv = cur ^ 3'd4;
      8'h34: nv = cur ^ 3'd2;
      8'h32: nv = cur ^ 3'd1;
      8'h1D: nv = 3'd7;
      8'h42: nv = 3'd0;
      8'h29: nv = DEF;
      default: return 1'b0;
    endcase
    return 1'b1;
  endfunction

  task automatic modelStep(input bit cv, input logic [7:0] d, input bit fs);
    bit         applied;
    logic [2:0] nv;
    applied = 0; nv = mPend; mStrobe = 0; mErr = 0;
    if (fs && mFlag) begin
      mColor = mPend; mStrobe = 1; mFlag = 0;
    end
    if (cv) begin
      mIdle = 0;
      case (mMode)
        0: begin
          if (d == 8'hF0) mMode = 1;
          else if (d == 8'hE0) mMode = 2;
          else if (d == 8'hFA || d == 8'hAA) mMode = 0;
          else if (makeCmd(d, mPend, nv)) applied = 1;
          else mErr = 1;
        end
        2: begin
          mMode = 0;
          if (d == 8'hF0) mMode = 3;
          else if (d == 8'hE0) mMode = 2;
          else if (d == 8'h75) begin applied = 1; nv = 3'((int'(mPend) + 1) % 8); end
          else if (d == 8'h72) begin applied = 1; nv = 3'((int'(mPend) + 7) % 8); end
          else mErr = 1;
        end
        default: mMode = 0;
      endcase
    end else if (mMode != 0) begin
      mIdle++;
      if (mIdle >= TMO) begin
        mMode = 0; mErr = 1;
      end
    end
    if (applied) begin
      mPend = nv; mFlag = 1;
    end
  endtask

  // ---------------- helpers ----------------
  task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // One clock: drive at negedge, model at posedge, leave outputs ready to sample.
  task automatic cycle(input bit cv, input logic [7:0] d, input bit fs);
    @(negedge boardClk);
    codeValid = cv; codeData = d; frameStart = fs;
    @(posedge boardClk);
    modelStep(cv, d, fs);
    #1;
    codeValid = 1'b0; codeData = 8'h00; frameStart = 1'b0;
  endtask

  typedef struct {
    bit         cv;
    logic [7:0] d;
    bit         fs;
    logic [2:0] color;
    bit         pend;
    bit         strobe;
    bit         err;
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t mk(input bit cv, input logic [7:0] d, input bit fs,
                              input logic [2:0] color, input bit pend,
                              input bit strobe, input bit err);
    vec_t v;
    v.cv = cv; v.d = d; v.fs = fs; v.color = color;
    v.pend = pend; v.strobe = strobe; v.err = err;
    return v;
  endfunction

  logic [7:0] pool [13] = '{8'hF0, 8'hE0, 8'hFA, 8'hAA, 8'h2D, 8'h34, 8'h32,
                            8'h1D, 8'h42, 8'h29, 8'h75, 8'h72, 8'h00};

  initial begin
    int         dens;
    int         idx;
    bit         rcv;
    bit         rfs;
    logic [7:0] rd;

    // basic commit from DEF=010
    vecs.push_back(mk(1, 8'h2D, 0, 3'b010, 1, 0, 0));
    vecs.push_back(mk(0, 8'h00, 1, 3'b110, 0, 1, 0));
    vecs.push_back(mk(0, 8'h00, 0, 3'b110, 0, 0, 0));
    // break and extended sequences
    vecs.push_back(mk(1, 8'hF0, 0, 3'b110, 0, 0, 0));
    vecs.push_back(mk(1, 8'h2D, 0, 3'b110, 0, 0, 0));
    vecs.push_back(mk(1, 8'hE0, 0, 3'b110, 0, 0, 0));
    vecs.push_back(mk(1, 8'h75, 0, 3'b110, 1, 0, 0));
    vecs.push_back(mk(1, 8'hE0, 0, 3'b110, 1, 0, 0));
    vecs.push_back(mk(1, 8'h75, 0, 3'b110, 1, 0, 0));
    vecs.push_back(mk(1, 8'hE0, 0, 3'b110, 1, 0, 0));
    vecs.push_back(mk(1, 8'h72, 0, 3'b110, 1, 0, 0));
    vecs.push_back(mk(1, 8'hE0, 0, 3'b110, 1, 0, 0));
    vecs.push_back(mk(1, 8'hF0, 0, 3'b110, 1, 0, 0));
    vecs.push_back(mk(1, 8'h75, 0, 3'b110, 1, 0, 0));
    vecs.push_back(mk(0, 8'h00, 1, 3'b111, 0, 1, 0));
    // wrap-around up and down
    vecs.push_back(mk(1, 8'h1D, 0, 3'b111, 1, 0, 0));
    vecs.push_back(mk(1, 8'hE0, 0, 3'b111, 1, 0, 0));
    vecs.push_back(mk(1, 8'h75, 0, 3'b111, 1, 0, 0));
    vecs.push_back(mk(0, 8'h00, 1, 3'b000, 0, 1, 0));
    vecs.push_back(mk(1, 8'h42, 0, 3'b000, 1, 0, 0));
    vecs.push_back(mk(1, 8'hE0, 0, 3'b000, 1, 0, 0));
    vecs.push_back(mk(1, 8'h72, 0, 3'b000, 1, 0, 0));
    vecs.push_back(mk(0, 8'h00, 1, 3'b111, 0, 1, 0));
    // unknown code, ignored codes, Space, commit with nothing pending
    vecs.push_back(mk(1, 8'h1C, 0, 3'b111, 0, 0, 1));
    vecs.push_back(mk(0, 8'h00, 0, 3'b111, 0, 0, 0));
    vecs.push_back(mk(1, 8'hAA, 0, 3'b111, 0, 0, 0));
    vecs.push_back(mk(1, 8'hFA, 0, 3'b111, 0, 0, 0));
    vecs.push_back(mk(1, 8'h29, 0, 3'b111, 1, 0, 0));
    vecs.push_back(mk(0, 8'h00, 1, 3'b010, 0, 1, 0));
    vecs.push_back(mk(0, 8'h00, 1, 3'b010, 0, 0, 0));
    // simultaneous command and commit
    vecs.push_back(mk(1, 8'h29, 0, 3'b010, 1, 0, 0));
    vecs.push_back(mk(1, 8'h34, 1, 3'b010, 1, 1, 0));
    vecs.push_back(mk(0, 8'h00, 1, 3'b000, 0, 1, 0));

    // reset state
    modelReset();
    #12;
    chk("rst_color", colorOut, DEF);
    chk("rst_pend", cmdPending, 0);
    chk("rst_strobe", commitStrobe, 0);
    chk("rst_err", errPulse, 0);
    @(negedge boardClk);
    reset = 1'b1;

    // directed vector table
    for (int i = 0; i < vecs.size(); i++) begin
      cycle(vecs[i].cv, vecs[i].d, vecs[i].fs);
      chk($sformatf("vec%0d_color", i), colorOut, vecs[i].color);
      chk($sformatf("vec%0d_pend", i), cmdPending, vecs[i].pend);
      chk($sformatf("vec%0d_strobe", i), commitStrobe, vecs[i].strobe);
      chk($sformatf("vec%0d_err", i), errPulse, vecs[i].err);
    end

    // prefix timeout after exactly TMO idle cycles, then normal decoding
    cycle(1, 8'hE0, 0);
    for (int i = 1; i < TMO; i++) begin
      cycle(0, 8'h00, 0);
      chk($sformatf("tmo_early%0d", i), errPulse, 0);
    end
    cycle(0, 8'h00, 0);
    chk("tmo_err", errPulse, 1);
    cycle(1, 8'h2D, 0);
    chk("tmo_after_err", errPulse, 0);
    chk("tmo_after_pend", cmdPending, 1);
    cycle(0, 8'h00, 1);
    chk("tmo_after_color", colorOut, 3'b100);
    chk("tmo_after_strobe", commitStrobe, 1);

    // byte arriving on the last cycle before timeout is still an extended code
    cycle(1, 8'hE0, 0);
    for (int i = 1; i < TMO; i++) cycle(0, 8'h00, 0);
    cycle(1, 8'h75, 0);
    chk("near_tmo_err", errPulse, 0);
    cycle(0, 8'h00, 1);
    chk("near_tmo_color", colorOut, 3'b101);

    // asynchronous reset while in EXT with a pending command
    cycle(1, 8'h42, 0);
    cycle(1, 8'h2D, 0);
    cycle(1, 8'h32, 0);
    cycle(1, 8'hE0, 0);
    chk("pre_rst_pend", cmdPending, 1);
    chk("pre_rst_color", colorOut, 3'b101);
    #2;
    reset = 1'b0;
    #1;
    chk("async_rst_color", colorOut, DEF);
    chk("async_rst_pend", cmdPending, 0);
    chk("async_rst_strobe", commitStrobe, 0);
    chk("async_rst_err", errPulse, 0);
    modelReset();
    @(negedge boardClk);
    @(negedge boardClk);
    reset = 1'b1;
    cycle(1, 8'h75, 0);
    chk("post_rst_lone75_err", errPulse, 1);
    cycle(0, 8'h00, 1);
    chk("post_rst_nostrobe", commitStrobe, 0);
    chk("post_rst_color", colorOut, DEF);

    // randomized traffic in bursts of varying density against the model
    for (int seg = 0; seg < 60; seg++) begin
      idx = $urandom_range(2);
      dens = (idx == 0) ? 3 : ((idx == 1) ? 40 : 95);
      for (int k = 0; k < 50; k++) begin
        rcv = ($urandom_range(99) < dens);
        rfs = ($urandom_range(9) == 0);
        idx = $urandom_range(13);
        rd = (idx == 13) ? 8'($urandom_range(255)) : pool[idx];
        cycle(rcv, rd, rfs);
        chk("rnd_color", colorOut, mColor);
        chk("rnd_pend", cmdPending, mFlag);
        chk("rnd_strobe", commitStrobe, mStrobe);
        chk("rnd_err", errPulse, mErr);
      end
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
